ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_step.sv | 38 +++
 rtl/ex_muldiv.sv | 134 +++++++++++++
 tb/tb_ex_muldiv.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// FSM state type and default datapath width.
package muldiv_pkg;

    localparam int DATA_BITS_DEF = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative multiplier/divider: radix-2 shift-add for
// multiply, restoring shift-subtract for divide, on unsigned magnitudes.
module muldiv_step #(
    parameter int W = 32
) (
    input  logic         is_div,
    input  logic [W-1:0] acc_hi,
    input  logic [W-1:0] acc_lo,
    input  logic [W-1:0] operand,
    output logic [W-1:0] next_hi,
    output logic [W-1:0] next_lo
);

    logic [W:0]   sum;
    logic [W:0]   shifted;
    logic [W+1:0] diff;

    always_comb begin
        // Multiply: acc_lo holds the unconsumed multiplier bits, LSB first.
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(W+1){1'b0}});
        // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
        shifted = {acc_hi, acc_lo[W-1]};
        diff    = {1'b0, shifted} - {2'b00, operand};
        if (is_div) begin
            if (!diff[W+1]) begin
                next_hi = diff[W-1:0];
                next_lo = {acc_lo[W-2:0], 1'b1};
            end else begin
                next_hi = shifted[W-1:0];
                next_lo = {acc_lo[W-2:0], 1'b0};
            end
        end else begin
            next_hi = sum[W:1];
            next_lo = {sum[0], acc_lo[W-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Handshake: start is taken only in IDLE (and not under flush); stall_req holds the pipeline until DONE, where done pulses with hi/lo already valid.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [DATA_BITS-1:0] a,
    input  logic [DATA_BITS-1:0] b,
    input  logic                 flush,
    output logic                 busy,
    output logic                 stall_req,
    output logic                 done,
    output logic [DATA_BITS-1:0] hi,
    output logic [DATA_BITS-1:0] lo,
    output state_e               dbg_state
);

    localparam int CW = $clog2(DATA_BITS) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

    state_e               state, state_next;
    logic [CW-1:0]        cnt;
    logic [DATA_BITS-1:0] acc_hi, acc_lo, operand;
    logic                 is_div, neg_res, neg_rem, div_zero;

    logic                 signed_op, neg_a, neg_b, take;
    logic [DATA_BITS-1:0] mag_a, mag_b;
    logic [DATA_BITS-1:0] step_hi, step_lo;
    logic [DATA_BITS-1:0] fix_hi, fix_lo;
    logic [2*DATA_BITS-1:0] prod;

    muldiv_step #(.W(DATA_BITS)) u_step (
        .is_div  (is_div),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (operand),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_comb begin
        signed_op = ~op[0];
        neg_a     = signed_op & a[DATA_BITS-1];
        neg_b     = signed_op & b[DATA_BITS-1];
        mag_a     = neg_a ? -a : a;
        mag_b     = neg_b ? -b : b;
        take      = start & ~flush & (state == ST_IDLE);
    end

    // Sign fix-up; for divide-by-zero the remainder rule already yields hi = a.
    always_comb begin
        prod   = {acc_hi, acc_lo};
        fix_hi = acc_hi;
        fix_lo = acc_lo;
        if (!is_div) begin
            {fix_hi, fix_lo} = neg_res ? -prod : prod;
        end else begin
            fix_hi = neg_rem ? -acc_hi : acc_hi;
            if (div_zero) fix_lo = '1;
            else          fix_lo = neg_res ? -acc_lo : acc_lo;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (take) state_next = op[1] ? ST_DIV : ST_MUL;
            ST_MUL:  if (cnt == LAST) state_next = ST_FIX;
            ST_DIV:  if (cnt == LAST) state_next = ST_FIX;
            ST_FIX:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush) state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state_next == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        cnt      <= '0;
                        is_div   <= op[1];
                        neg_res  <= neg_a ^ neg_b;
                        neg_rem  <= neg_a;
                        div_zero <= (b == '0);
                        acc_hi   <= '0;
                        acc_lo   <= op[1] ? mag_a : mag_b;
                        operand  <= op[1] ? mag_b : mag_a;
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 1'b1;
                end
                ST_FIX: begin
                    if (state_next == ST_DONE) begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = ~rst & (state != ST_IDLE);
        stall_req = ~rst & (take | (state == ST_MUL) | (state == ST_DIV) | (state == ST_FIX));
        dbg_state = state;
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: results, latency, stall window,
// flush/reset aborts and start-while-busy.
module tb_ex_muldiv;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, stall_req, done;
    logic [31:0] hi, lo;
    state_e      dbg_state;

    int checks = 0;
    int errors = 0;

    ex_muldiv #(.DATA_BITS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start at cycle t, watch until done; poke>0 drives a stray start at t+poke.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int poke);
        int lat;
        int stalls;
        lat = 0;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        check({tag, " done@t"}, 64'(done), 64'd0);
        stalls = int'(stall_req);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                check({tag, " stall@done"}, 64'(stall_req), 64'd0);
                break;
            end
            stalls += int'(stall_req);
            @(posedge clk); #1;
            start = (i + 1 == poke);
            if (start) begin
                op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'h1234_5678;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'd34);
        check({tag, " stall_cycles"}, 64'(stalls), 64'd34);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = OP_MULT; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst stall", 64'(stall_req), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
        run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
        run_op("div_negb",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
        run_op("divu_zero", OP_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 0);
        run_op("div_zero",  OP_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 0);
        run_op("divu_one",  OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 0);
        run_op("multu_poke", OP_MULTU, 32'h1234_5678, 32'h10,       32'h0000_0001, 32'h2345_6780, 5);
        run_op("divu_100_7", OP_DIVU, 32'd100,       32'd7,         32'd2,         32'd14, 0);

        // Flush at t+10 of a MULT.
        seen = 0;
        @(posedge clk); #1;
        start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(negedge clk); seen += int'(done);
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush busy@t+10", 64'(busy), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        seen += int'(done);
        check("flush busy@t+11", 64'(busy), 64'd0);
        check("flush no_done", 64'(seen), 64'd0);
        check("flush hi", 64'(hi), 64'd2);
        check("flush lo", 64'(lo), 64'd14);
        run_op("after_flush", OP_MULTU, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780, 0);

        // Reset at t+5 of a DIV.
        seen = 0;
        @(posedge clk); #1;
        start = 1'b1; op = OP_DIV; a = 32'hFFFF_FF9C; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(negedge clk); seen += int'(done);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst stall", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst hi", 64'(hi), 64'd0);
        check("midrst lo", 64'(lo), 64'd0);
        check("midrst state", 64'(dbg_state), 64'(ST_IDLE));
        repeat (40) begin
            @(posedge clk); #1;
            @(negedge clk); seen += int'(done);
        end
        check("midrst no_done", 64'(seen), 64'd0);

        // start together with flush in IDLE.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd5;
        @(negedge clk);
        check("startflush stall", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("startflush busy", 64'(busy), 64'd0);
        check("startflush state", 64'(dbg_state), 64'(ST_IDLE));

        run_op("final_divu", OP_DIVU, 32'd50, 32'd5, 32'd0, 32'd10, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
